// File: rtl/psum_accum_ofifo.sv
// Banked partial-sum accumulator with per-column / 2-bit SIMD lane arithmetic, optional ReLU and show-ahead output FIFO.
// Build option: define SATURATE_EN to clamp sums per column/lane; otherwise sums wrap.
module psum_accum_ofifo #(
  parameter int unsigned col        = 8,
  parameter int unsigned psum_bw    = 16,
  parameter int unsigned acc_depth  = 16,
  parameter int unsigned fifo_depth = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [psum_bw*col-1:0]          in,
  input  logic                            valid_in,
  output logic                            in_ready,
  input  logic [$clog2(acc_depth)-1:0]    acc_addr,
  input  logic                            acc_en,
  input  logic                            last_in,
  input  logic                            relu_en,
  input  logic                            mode_2b,
  output logic [psum_bw*col-1:0]          out,
  output logic                            out_valid,
  input  logic                            out_rd,
  output logic                            o_full,
  output logic [$clog2(fifo_depth):0]     count
);

  localparam int unsigned DW = psum_bw * col;
  localparam int unsigned HW = psum_bw / 2;
  localparam int unsigned FW = $clog2(fifo_depth);
  localparam int unsigned CW = FW + 1;

  logic [DW-1:0] acc_q [acc_depth];
  logic [DW-1:0] mem_q [fifo_depth];
  logic [FW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [DW-1:0] acc_rd;
  logic [DW-1:0] sum;
  logic [DW-1:0] push_data;
  logic          accept;
  logic          push;
  logic          pop;

  // Full-width signed add of one column
  function automatic logic [psum_bw-1:0] add_col(input logic [psum_bw-1:0] a,
                                                  input logic [psum_bw-1:0] b);
`ifdef SATURATE_EN
    logic [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      add_col = {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}};
    else
      add_col = s[psum_bw-1:0];
`else
    add_col = a + b;
`endif
  endfunction

  // Half-width signed add of one SIMD lane; no carry leaves the lane
  function automatic logic [HW-1:0] add_lane(input logic [HW-1:0] a,
                                             input logic [HW-1:0] b);
`ifdef SATURATE_EN
    logic [HW:0] s;
    s = {a[HW-1], a} + {b[HW-1], b};
    if (s[HW] != s[HW-1])
      add_lane = {s[HW], {(HW-1){~s[HW]}}};
    else
      add_lane = s[HW-1:0];
`else
    add_lane = a + b;
`endif
  endfunction

  function automatic logic [psum_bw-1:0] relu_col(input logic [psum_bw-1:0] a);
    relu_col = a[psum_bw-1] ? '0 : a;
  endfunction

  function automatic logic [HW-1:0] relu_lane(input logic [HW-1:0] a);
    relu_lane = a[HW-1] ? '0 : a;
  endfunction

  // Handshake and occupancy flags come only from the registered count
  assign o_full    = (count_q == CW'(fifo_depth));
  assign in_ready  = ~o_full;
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign out       = out_valid ? mem_q[rd_ptr_q] : '0;

  assign accept = valid_in && in_ready && !reset;
  assign push   = accept && last_in;
  assign pop    = out_valid && out_rd && !reset;

  assign acc_rd = acc_q[acc_addr];

  // Per-column datapath: accumulate (or load), then optional ReLU for the push path
  always_comb begin : datapath
    logic [psum_bw-1:0] a, b, s, r;
    sum       = '0;
    push_data = '0;
    for (int unsigned c = 0; c < col; c++) begin
      a = acc_rd[c*psum_bw +: psum_bw];
      b = in[c*psum_bw +: psum_bw];
      if (!acc_en)
        s = b;
      else if (mode_2b)
        s = {add_lane(a[psum_bw-1:HW], b[psum_bw-1:HW]), add_lane(a[HW-1:0], b[HW-1:0])};
      else
        s = add_col(a, b);
      r = s;
      if (relu_en)
        r = mode_2b ? {relu_lane(s[psum_bw-1:HW]), relu_lane(s[HW-1:0])} : relu_col(s);
      sum[c*psum_bw +: psum_bw]       = s;
      push_data[c*psum_bw +: psum_bw] = r;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push)
      wr_ptr_d = wr_ptr_q + FW'(1);
    if (pop)
      rd_ptr_d = rd_ptr_q + FW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < acc_depth; i++)
        acc_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (accept)
        acc_q[acc_addr] <= last_in ? '0 : sum;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage needs no reset: out is gated by out_valid
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_psum_accum_ofifo.sv
// Self-checking bench for psum_accum_ofifo with an arithmetic reference model and a result queue.
// Honours SATURATE_EN the same way the design does.
module tb_psum_accum_ofifo;

  localparam int COL = 8;
  localparam int PW  = 16;
  localparam int HW  = 8;
  localparam int AD  = 16;
  localparam int FD  = 4;
  localparam int DW  = COL * PW;
  localparam int AW  = 4;
  localparam int CW  = 3;

  logic          clk;
  logic          reset;
  logic [DW-1:0] din;
  logic          valid_in;
  logic          in_ready;
  logic [AW-1:0] acc_addr;
  logic          acc_en;
  logic          last_in;
  logic          relu_en;
  logic          mode_2b;
  logic [DW-1:0] dout;
  logic          out_valid;
  logic          out_rd;
  logic          o_full;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] m_acc [AD];
  logic [DW-1:0] mq [$];

  psum_accum_ofifo #(.col(COL), .psum_bw(PW), .acc_depth(AD), .fifo_depth(FD)) dut (
    .clk(clk), .reset(reset), .in(din), .valid_in(valid_in), .in_ready(in_ready),
    .acc_addr(acc_addr), .acc_en(acc_en), .last_in(last_in), .relu_en(relu_en),
    .mode_2b(mode_2b), .out(dout), .out_valid(out_valid), .out_rd(out_rd),
    .o_full(o_full), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic longint unit_get(input logic [DW-1:0] v, input int base, input int w);
    longint r;
    r = 0;
    for (int k = 0; k < w; k++) r[k] = v[base+k];
    if (r[w-1]) r = r - (longint'(1) << w);
    return r;
  endfunction

  function automatic logic [DW-1:0] unit_put(input logic [DW-1:0] v, input int base,
                                            input int w, input longint x);
    logic [DW-1:0] r;
    r = v;
    for (int k = 0; k < w; k++) r[base+k] = x[k];
    return r;
  endfunction

  function automatic longint fit(input longint s, input int w);
    longint lim;
    longint t;
    lim = longint'(1) << (w - 1);
    t = s;
`ifdef SATURATE_EN
    if (t > lim - 1) t = lim - 1;
    if (t < -lim) t = -lim;
`else
    t = t & ((lim << 1) - 1);
    if (t >= lim) t = t - (lim << 1);
`endif
    return t;
  endfunction

  function automatic logic [DW-1:0] model_sum(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic en, input logic mode);
    logic [DW-1:0] r;
    int w;
    if (!en) return b;
    w = mode ? HW : PW;
    r = '0;
    for (int u = 0; u < DW / w; u++)
      r = unit_put(r, u*w, w, fit(unit_get(a, u*w, w) + unit_get(b, u*w, w), w));
    return r;
  endfunction

  function automatic logic [DW-1:0] model_relu(input logic [DW-1:0] v, input logic mode);
    logic [DW-1:0] r;
    int w;
    w = mode ? HW : PW;
    r = v;
    for (int u = 0; u < DW / w; u++)
      if (unit_get(v, u*w, w) < 0) r = unit_put(r, u*w, w, 0);
    return r;
  endfunction

  function automatic logic [DW-1:0] all_cols(input logic [PW-1:0] v);
    logic [DW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PW +: PW] = v;
    return r;
  endfunction

  function automatic logic [DW-1:0] lanes(input logic [HW-1:0] lo, input logic [HW-1:0] hi);
    logic [DW-1:0] r;
    for (int c = 0; c < COL; c++) r[c*PW +: PW] = {hi, lo};
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    logic [7:0] b;
    for (int i = 0; i < DW / 8; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 8'h7F;
        1:       b = 8'h80;
        default: b = 8'($urandom);
      endcase
      r[i*8 +: 8] = b;
    end
    return r;
  endfunction

  // Advance the model by the current inputs, then one clock; samples later land #1 after the edge
  task automatic tick();
    bit acc_ok;
    bit pop_ok;
    logic [DW-1:0] s;
    s = '0;
    if (reset) begin
      for (int i = 0; i < AD; i++) m_acc[i] = '0;
      mq.delete();
    end else begin
      acc_ok = valid_in && (mq.size() < FD);
      pop_ok = out_rd && (mq.size() > 0);
      if (acc_ok) s = model_sum(m_acc[acc_addr], din, acc_en, mode_2b);
      if (pop_ok) void'(mq.pop_front());
      if (acc_ok) begin
        if (last_in) begin
          mq.push_back(relu_en ? model_relu(s, mode_2b) : s);
          m_acc[acc_addr] = '0;
        end else begin
          m_acc[acc_addr] = s;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0; last_in = 1'b0; acc_en = 1'b0; relu_en = 1'b0;
    mode_2b = 1'b0; acc_addr = '0; din = '0;
  endtask

  task automatic beat(input int addr, input logic [DW-1:0] d, input logic en,
                      input logic last, input logic relu, input logic mode);
    valid_in = 1'b1; acc_addr = AW'(addr); din = d; acc_en = en;
    last_in = last; relu_en = relu; mode_2b = mode;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); out_rd = 1'b0; reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (dout !== '0) begin n_err++; $display("FAIL reset_out: got %h expected 0", dout); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (o_full !== 1'b0) begin n_err++; $display("FAIL reset_o_full: got %b expected 0", o_full); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_group();
    beat(3, all_cols(16'd5), 1'b0, 1'b0, 1'b0, 1'b0);
    beat(3, all_cols(16'd7), 1'b1, 1'b0, 1'b0, 1'b0);
    beat(3, all_cols(16'hFFEC), 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL group_out_valid: got %b expected 1", out_valid); end
    n_cmp++; if (dout !== all_cols(16'hFFF8)) begin n_err++; $display("FAIL group_out: got %h expected %h", dout, all_cols(16'hFFF8)); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL group_count: got %0d expected 1", count); end
    // zero beat into addr 3 exposes whether the entry was cleared
    beat(3, all_cols(16'd0), 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL group_count2: got %0d expected 2", count); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    n_cmp++; if (dout !== '0 || out_valid !== 1'b1) begin n_err++; $display("FAIL group_acc_cleared: got %h/%b expected 0/1", dout, out_valid); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || dout !== '0) begin n_err++; $display("FAIL group_empty: got %b/%h expected 0/0", out_valid, dout); end
  endtask

  task automatic test_interleave();
    beat(0, all_cols(16'd1), 1'b0, 1'b0, 1'b0, 1'b0);
    beat(1, all_cols(16'd0), 1'b0, 1'b0, 1'b0, 1'b0);
    beat(0, all_cols(16'd2), 1'b1, 1'b0, 1'b0, 1'b0);
    beat(1, all_cols(16'd10), 1'b1, 1'b0, 1'b0, 1'b0);
    beat(0, all_cols(16'd3), 1'b1, 1'b1, 1'b0, 1'b0);
    beat(1, all_cols(16'd20), 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL ilv_count: got %0d expected 2", count); end
    n_cmp++; if (dout !== all_cols(16'd6)) begin n_err++; $display("FAIL ilv_first: got %h expected %h", dout, all_cols(16'd6)); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    n_cmp++; if (dout !== all_cols(16'd30)) begin n_err++; $display("FAIL ilv_second: got %h expected %h", dout, all_cols(16'd30)); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
  endtask

  task automatic test_lanes();
    logic [DW-1:0] exp_a, exp_b;
`ifdef SATURATE_EN
    exp_a = lanes(8'h7F, 8'hFF);
    exp_b = lanes(8'h7F, 8'h00);
`else
    exp_a = lanes(8'h80, 8'hFF);
    exp_b = lanes(8'h00, 8'h00);
`endif
    beat(4, lanes(8'h7F, 8'h01), 1'b0, 1'b0, 1'b0, 1'b1);
    beat(4, lanes(8'h01, 8'hFE), 1'b1, 1'b1, 1'b0, 1'b1);
    beat(4, lanes(8'h7F, 8'h01), 1'b0, 1'b0, 1'b0, 1'b1);
    beat(4, lanes(8'h01, 8'hFE), 1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    n_cmp++; if (dout !== exp_a) begin n_err++; $display("FAIL lanes_raw: got %h expected %h", dout, exp_a); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    n_cmp++; if (dout !== exp_b) begin n_err++; $display("FAIL lanes_relu: got %h expected %h", dout, exp_b); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lanes_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] x, y;
    x = rand_vec(); y = rand_vec();
    beat(5, x, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FD; i++) beat(i, rand_vec(), 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    n_cmp++; if (o_full !== 1'b1) begin n_err++; $display("FAIL bp_o_full: got %b expected 1", o_full); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_cmp++; if (count !== 3'(FD)) begin n_err++; $display("FAIL bp_count: got %0d expected %0d", count, FD); end
    beat(5, y, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall: got %b expected 0", in_ready); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || count !== 3'(FD-1)) begin n_err++; $display("FAIL bp_freed: got %b/%0d expected 1/%0d", in_ready, count, FD-1); end
    tick();
    idle();
    n_cmp++; if (count !== 3'(FD) || o_full !== 1'b1) begin n_err++; $display("FAIL bp_refill: got %0d/%b expected %0d/1", count, o_full, FD); end
    for (int i = 0; i < FD && mq.size() > 0; i++) begin
      n_cmp++; if (dout !== mq[0]) begin n_err++; $display("FAIL bp_drain%0d: got %h expected %h", i, dout, mq[0]); end
      out_rd = 1'b1; tick(); out_rd = 1'b0;
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
  endtask

  task automatic test_stream();
    out_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i > 1) begin
        n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL stream_count%0d: got %0d expected 1", i, count); end
      end
      if (mq.size() > 0) begin
        n_cmp++; if (dout !== mq[0]) begin n_err++; $display("FAIL stream_out%0d: got %h expected %h", i, dout, mq[0]); end
      end
      beat($urandom_range(0, AD-1), rand_vec(), 1'($urandom), 1'b1, 1'($urandom), 1'($urandom));
    end
    idle();
    n_cmp++; if (mq.size() == 0 || dout !== mq[0]) begin n_err++; $display("FAIL stream_tail: got %h expected model head", dout); end
    tick();
    out_rd = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || count !== '0) begin n_err++; $display("FAIL stream_empty: got %b/%0d expected 0/0", out_valid, count); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      last_in  = (i < 200) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 3) == 0);
      acc_en   = 1'($urandom); relu_en = 1'($urandom); mode_2b = 1'($urandom);
      acc_addr = AW'($urandom_range(0, 3));
      out_rd   = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      din      = rand_vec();
      n_cmp++; if (count !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_count%0d: got %0d expected %0d", i, count, mq.size()); end
      n_cmp++; if (in_ready !== (mq.size() < FD)) begin n_err++; $display("FAIL rnd_ready%0d: got %b", i, in_ready); end
      n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_valid%0d: got %b", i, out_valid); end
      if (mq.size() > 0) begin
        n_cmp++; if (dout !== mq[0]) begin n_err++; $display("FAIL rnd_out%0d: got %h expected %h", i, dout, mq[0]); end
      end
      tick();
    end
    idle(); out_rd = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) beat(i, rand_vec(), 1'b0, 1'b1, 1'b0, 1'b0);
    beat(2, all_cols(16'd9), 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL rstm_pre_count: got %0d expected 3", count); end
    reset = 1'b1; valid_in = 1'b1; last_in = 1'b1; acc_addr = AW'(2); din = rand_vec(); out_rd = 1'b1;
    tick();
    reset = 1'b0; out_rd = 1'b0; idle();
    n_cmp++; if (out_valid !== 1'b0 || dout !== '0) begin n_err++; $display("FAIL rstm_out: got %b/%h expected 0/0", out_valid, dout); end
    n_cmp++; if (count !== '0 || in_ready !== 1'b1) begin n_err++; $display("FAIL rstm_count: got %0d/%b expected 0/1", count, in_ready); end
    beat(2, all_cols(16'd1), 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    n_cmp++; if (dout !== all_cols(16'd1) || count !== 3'd1) begin n_err++; $display("FAIL rstm_after: got %h/%0d expected %h/1", dout, count, all_cols(16'd1)); end
    out_rd = 1'b1; tick(); out_rd = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < AD; i++) m_acc[i] = '0;
    test_reset();
    test_group();
    test_interleave();
    test_lanes();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accum_ofifo.md
# psum_accum_ofifo

Parametrised successor to the SFP + output-FIFO path of the accelerator core. Accumulates per-column partial sums from the MAC array into an addressable bank of accumulators, so several output tiles can accumulate concurrently. Supports 4-bit mode (one lane per column) and 2-bit SIMD mode (two lanes per column). On the last beat of a group it applies optional ReLU and pushes the result into a parametrised-depth output FIFO with a ready/valid handshake toward PSUM SRAM.

## Interface
- col, 8, number of MAC columns
- psum_bw, 16, bits per column word; must be even
- acc_depth, 16, number of accumulator entries (power of 2, ≥2)
- fifo_depth, 16, output FIFO entries (power of 2, ≥2)

- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high
- in  input  psum_bw*col  column partial sums, column 0 in LSBs
- valid_in  input  1  beat present on in
- in_ready  output  1  beat accepted when valid_in && in_ready
- acc_addr  input  clog2(acc_depth)  accumulator entry for this beat
- acc_en  input  1  1: add to entry; 0: overwrite entry with in
- last_in  input  1  final beat of group; result pushed to FIFO
- relu_en  input  1  apply ReLU to pushed result
- mode_2b  input  1  1: two signed psum_bw/2 lanes per column
- out  output  psum_bw*col  FIFO head (show-ahead)
- out_valid  output  1  FIFO not empty
- out_rd  input  1  pop head when out_valid
- o_full  output  1  FIFO holds fifo_depth entries
- count  output  clog2(fifo_depth)+1  FIFO occupancy

## Operation
- Handshake: in_ready = !o_full. All beats, accumulate-only or last, stall while full; beats with valid_in && !in_ready are not consumed and do not modify state.
- Accepted beat: sum = acc_en ? acc[acc_addr] + in : in, computed per column, or per lane when mode_2b=1. acc[acc_addr] <= sum.
- Lane rule, mode_2b=1: low and high psum_bw/2 halves are independent signed values. No carry crosses the lane boundary.
- Arithmetic is signed two's complement. Overflow handling is set by SATURATE_EN.
- last_in on an accepted beat: push relu_en ? max(sum,0) per column/lane : sum into the FIFO. Clear acc[acc_addr] to 0.
- Entries hold raw bits. Each beat is interpreted using that beat's mode_2b. Mode changes within a group are legal but produce the per-lane/per-column arithmetic of each beat.
- Pop: out_valid && out_rd advances the head. out_rd while empty is ignored.
- Push and pop in the same cycle: count unchanged. When full, no push is possible because in_ready=0, so a pop frees a slot visible the next cycle.
- Read and write pointers wrap modulo fifo_depth.

## Timing
- Accumulator update: 1 cycle. A beat to the same acc_addr on the next cycle sees the updated value, so back-to-back beats need no hazard stall.
- Push latency: a last_in beat accepted at edge N gives out_valid=1, with out showing the result, after edge N if the FIFO was empty.
- in_ready and o_full are combinational from the registered count, with no path from valid_in.
- out is 0 whenever out_valid=0.
- Reset, including mid-group or with a non-empty FIFO:
  - all acc entries = 0, FIFO emptied, count = 0
  - out_valid = 0, out = 0, o_full = 0, in_ready = 1
  - Inputs during the reset cycle are ignored.

## Configuration
- SATURATE_EN defined: each column/lane sum clamps to [-2^(w-1), 2^(w-1)-1], where w = psum_bw or psum_bw/2.
- SATURATE_EN undefined: sums wrap modulo 2^w.
- Either way, lane isolation in 2-bit mode is preserved.

## Test plan
- Group test, psum_bw=16, col=8, 4-bit mode:
  - Stimulus: beats to addr 3 of all columns = 5, acc_en=0; then 7, acc_en=1; then −20, acc_en=1 with last_in=1 and relu_en=0.
  - Required: out = −8 in every column, out_valid one cycle later, count=1, acc[3]=0.
- Interleaved groups: addr 0 accumulates 1+2+3 and addr 1 accumulates 10+20, beats alternating every cycle → pushes 6 then 30, in that order.
- 2-bit lanes: beat with lane values low=0x7F, high=0x01, then low=0x01, high=−2 with last_in=1.
  - SATURATE_EN defined: low=0x7F, high=−1.
  - SATURATE_EN undefined: low=0x80, high=−1.
  - High lane unaffected by low-lane overflow in both cases.
  - With relu_en=1, high lane = 0.
- Backpressure with fifo_depth=4: push 4 results → o_full=1, in_ready=0. A stalled beat leaves its acc entry unchanged. One out_rd → the stalled beat is accepted next cycle, count returns to 4.
- Wrap and simultaneous events:
  - Stream 20 last beats with out_rd held high → outputs emerge in order, count ≤1.
  - Push and pop in the same cycle → count unchanged.
- Reset mid-operation: assert reset with 3 FIFO entries and partial acc[2]=9 → out_valid=0, count=0. A following last beat with acc_en=1 and in=1 to addr 2 outputs 1.
